io_controller: RTL and testbench

Memory-mapped I/O peripheral that sits between the core's load/store path and the board pins. It is the device-side end of `io_input_bus`/`io_output_bus`. It owns the LED and seven-segment output registers and drives `io_output_bus` from them. It also synchronises and debounces `io_input_bus` and presents switch, button and button-event registers to core loads.

---
 rtl/io_controller.sv | 164 ++++++++++++++++
 tb/tb_io_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_controller.sv
// io_controller: memory-mapped LED / seven-segment / switch / button peripheral.
// Pins are double-synchronised; buttons are debounced and raise sticky rising-edge flags.
module io_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [13:0] io_input_bus,
   output logic [51:0] io_output_bus
);

   localparam int unsigned NUM_SW  = 10;
   localparam int unsigned NUM_BTN = 4;
   localparam int unsigned NUM_DIG = 6;
   localparam int unsigned IN_W    = NUM_SW + NUM_BTN;
   localparam int unsigned OUT_W   = NUM_SW + 7 * NUM_DIG;
   localparam int unsigned CNT_W   = 16;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [OUT_W-1:0] OUT_RESET = {{(7*NUM_DIG){1'b1}}, {NUM_SW{1'b0}}};

   localparam logic [2:0] ADDR_LED     = 3'd0;
   localparam logic [2:0] ADDR_HEX_VAL = 3'd1;
   localparam logic [2:0] ADDR_HEX_EN  = 3'd2;
   localparam logic [2:0] ADDR_SW      = 3'd3;
   localparam logic [2:0] ADDR_BTN     = 3'd4;
   localparam logic [2:0] ADDR_BTN_EVT = 3'd5;

   logic [IN_W-1:0]                 sync1_q, sync1_d;
   logic [IN_W-1:0]                 sync2_q, sync2_d;
   logic [NUM_SW-1:0]               led_q, led_d;
   logic [4*NUM_DIG-1:0]            hex_val_q, hex_val_d;
   logic [NUM_DIG-1:0]              hex_en_q, hex_en_d;
   logic [NUM_BTN-1:0]              btn_q, btn_d;
   logic [NUM_BTN-1:0]              evt_q, evt_d;
   logic [NUM_BTN-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]                     rdata_q, rdata_d;
   logic [OUT_W-1:0]                out_q, out_d;

   logic                            wr_en;
   logic                            rd_en;
   logic [NUM_BTN-1:0]              btn_sync;
   logic [31:0]                     reg_val;
   logic                            unused_wdata;

   assign unused_wdata = ^wdata[31:24];

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0:    seg7 = 7'h40;
         4'h1:    seg7 = 7'h79;
         4'h2:    seg7 = 7'h24;
         4'h3:    seg7 = 7'h30;
         4'h4:    seg7 = 7'h19;
         4'h5:    seg7 = 7'h12;
         4'h6:    seg7 = 7'h02;
         4'h7:    seg7 = 7'h78;
         4'h8:    seg7 = 7'h00;
         4'h9:    seg7 = 7'h10;
         4'hA:    seg7 = 7'h08;
         4'hB:    seg7 = 7'h03;
         4'hC:    seg7 = 7'h46;
         4'hD:    seg7 = 7'h21;
         4'hE:    seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      wr_en     = sel & we;
      rd_en     = sel & ~we;
      sync1_d   = io_input_bus;
      sync2_d   = sync1_q;
      btn_sync  = sync2_q[IN_W-1:NUM_SW];
      led_d     = led_q;
      hex_val_d = hex_val_q;
      hex_en_d  = hex_en_q;
      btn_d     = btn_q;
      cnt_d     = cnt_q;
      evt_d     = evt_q;
      rdata_d   = rdata_q;
      reg_val   = '0;
      out_d     = '0;

      if (wr_en) begin
         case (addr)
            ADDR_LED:     led_d     = wdata[NUM_SW-1:0];
            ADDR_HEX_VAL: hex_val_d = wdata[4*NUM_DIG-1:0];
            ADDR_HEX_EN:  hex_en_d  = wdata[NUM_DIG-1:0];
            ADDR_BTN_EVT: evt_d     = evt_q & ~wdata[NUM_BTN-1:0];
            default:      ;
         endcase
      end

      // Counter runs only while the synchronised pin disagrees with the accepted level.
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         if (btn_sync[i] == btn_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            btn_d[i] = btn_sync[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      // A new rising edge overrides a same-cycle W1C.
      evt_d = evt_d | (btn_d & ~btn_q);

      case (addr)
         ADDR_LED:     reg_val = 32'(led_q);
         ADDR_HEX_VAL: reg_val = 32'(hex_val_q);
         ADDR_HEX_EN:  reg_val = 32'(hex_en_q);
         ADDR_SW:      reg_val = 32'(sync2_q[NUM_SW-1:0]);
         ADDR_BTN:     reg_val = 32'(btn_q);
         ADDR_BTN_EVT: reg_val = 32'(evt_q);
         default:      reg_val = '0;
      endcase
      if (rd_en) begin
         rdata_d = reg_val;
      end

      out_d[NUM_SW-1:0] = led_q;
      for (int d = 0; d < int'(NUM_DIG); d++) begin
         out_d[NUM_SW + 7*d +: 7] = hex_en_q[d] ? seg7(hex_val_q[4*d +: 4]) : 7'h7F;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         led_q     <= '0;
         hex_val_q <= '0;
         hex_en_q  <= '0;
         btn_q     <= '0;
         evt_q     <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         out_q     <= OUT_RESET;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         led_q     <= led_d;
         hex_val_q <= hex_val_d;
         hex_en_q  <= hex_en_d;
         btn_q     <= btn_d;
         evt_q     <= evt_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         out_q     <= out_d;
      end
   end

   assign rdata         = rdata_q;
   assign io_output_bus = out_q;

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: directed register/display/debounce scenarios followed by
// random bus traffic and button activity, all compared against a cycle-level reference model.
module tb_io_controller;

   localparam int unsigned D = 16;
   localparam logic [51:0] RESET_OUT = 52'hFFFFFFFFFFC00;

   logic        clock = 1'b0;
   logic        reset;
   logic        sel;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [13:0] io_input_bus;
   logic [51:0] io_output_bus;

   int n_checks = 0;
   int n_errors = 0;

   io_controller #(.DEBOUNCE_CYCLES(D)) dut (
      .clock         (clock),
      .reset         (reset),
      .sel           (sel),
      .we            (we),
      .addr          (addr),
      .wdata         (wdata),
      .rdata         (rdata),
      .io_input_bus  (io_input_bus),
      .io_output_bus (io_output_bus)
   );

   always #5 clock = ~clock;

   // Reference state: register file, pin samples from the last two edges, run lengths of disagreement.
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [9:0]  m_led;
   logic [23:0] m_hex;
   logic [5:0]  m_en;
   logic [3:0]  m_btn;
   logic [3:0]  m_evt;
   logic [31:0] m_rdata;
   logic [51:0] m_out;
   logic [13:0] pin_prev;
   logic [13:0] pin_prev2;
   int          run_len [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [31:0] regv [8];
      logic [3:0]  new_btn;
      logic [3:0]  clr;
      if (reset) begin
         m_led = '0; m_hex = '0; m_en = '0; m_btn = '0; m_evt = '0;
         m_rdata = '0; m_out = RESET_OUT; pin_prev = '0; pin_prev2 = '0;
         foreach (run_len[i]) run_len[i] = 0;
         return;
      end
      foreach (regv[i]) regv[i] = '0;
      regv[0] = 32'(m_led);
      regv[1] = 32'(m_hex);
      regv[2] = 32'(m_en);
      regv[3] = 32'(pin_prev2[9:0]);
      regv[4] = 32'(m_btn);
      regv[5] = 32'(m_evt);
      if (sel && !we) m_rdata = regv[addr];

      m_out[9:0] = m_led;
      for (int d = 0; d < 6; d++)
         m_out[10 + 7*d +: 7] = m_en[d] ? seg_tab[m_hex[4*d +: 4]] : 7'h7F;

      // A level is accepted once the synchronised pin has disagreed on D consecutive edges.
      new_btn = m_btn;
      for (int i = 0; i < 4; i++) begin
         if (pin_prev2[10+i] != m_btn[i]) begin
            run_len[i]++;
            if (run_len[i] == int'(D)) begin
               new_btn[i] = pin_prev2[10+i];
               run_len[i] = 0;
            end
         end else begin
            run_len[i] = 0;
         end
      end

      clr = (sel && we && addr == 3'd5) ? wdata[3:0] : 4'h0;
      m_evt = (m_evt & ~clr) | (new_btn & ~m_btn);
      if (sel && we) begin
         case (addr)
            3'd0: m_led = wdata[9:0];
            3'd1: m_hex = wdata[23:0];
            3'd2: m_en  = wdata[5:0];
            default: ;
         endcase
      end
      m_btn     = new_btn;
      pin_prev2 = pin_prev;
      pin_prev  = io_input_bus;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      chk("rdata", 64'(rdata), 64'(m_rdata));
      chk("io_output_bus", 64'(io_output_bus), 64'(m_out));
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick();
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      sel = 1'b1; we = 1'b0; addr = a;
      tick();
      sel = 1'b0;
      v = rdata;
   endtask

   logic [31:0] v;
   logic [6:0]  exp_dig [6] = '{7'h0E, 7'h40, 7'h03, 7'h08, 7'h7F, 7'h79};
   int          first;
   int          hold [4];

   initial begin
      reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; io_input_bus = '0;
      @(negedge clock);
      tick();
      reset = 1'b0;
      chk("reset_out", 64'(io_output_bus), 64'(RESET_OUT));
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), v);
         chk("reset_read", 64'(v), 64'h0);
      end

      wr(3'd0, 32'hFFFF_F2A5);
      tick();
      chk("led_field", 64'(io_output_bus[9:0]), 64'h2A5);
      rd(3'd0, v);
      chk("led_read", 64'(v), 64'h2A5);

      wr(3'd1, 32'h0012_AB0F);
      wr(3'd2, 32'h0000_002F);
      tick();
      for (int d = 0; d < 6; d++)
         chk("hex_digit", 64'(io_output_bus[10 + 7*d +: 7]), 64'(exp_dig[d]));

      io_input_bus[10] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rd((k % 2 == 0) ? 3'd4 : 3'd5, v);
         chk("glitch_hold", 64'(v[3:0]), 64'h0);
      end
      io_input_bus[10] = 1'b0;
      for (int k = 0; k < 20; k++) begin
         rd((k % 2 == 0) ? 3'd4 : 3'd5, v);
         chk("glitch_after", 64'(v[3:0]), 64'h0);
      end

      // Read k returns BTN as it stood before edge k; edge 1 is the pin's first sampling edge.
      io_input_bus[10] = 1'b1;
      first = 0;
      for (int j = 1; j <= 40; j++) begin
         rd(3'd4, v);
         if (v[0] && first == 0) first = j;
      end
      chk("btn0_latency", 64'(first - 2), 64'd17);
      io_input_bus[10] = 1'b0;
      rd(3'd5, v);
      chk("evt0_set", 64'(v[0]), 64'h1);
      wr(3'd5, 32'h1);
      rd(3'd5, v);
      chk("evt0_clear", 64'(v[0]), 64'h0);
      idle(25);

      io_input_bus[11] = 1'b1;
      idle(17);
      wr(3'd5, 32'h2);
      rd(3'd5, v);
      chk("evt1_collision", 64'(v[1]), 64'h1);
      io_input_bus[11] = 1'b0;
      idle(25);
      wr(3'd5, 32'h2);

      wr(3'd0, 32'h3FF);
      tick();
      chk("led_all_on", 64'(io_output_bus[9:0]), 64'h3FF);
      io_input_bus[12] = 1'b1;
      idle(8);
      reset = 1'b1;
      tick();
      chk("midrst_out", 64'(io_output_bus), 64'(RESET_OUT));
      chk("midrst_rdata", 64'(rdata), 64'h0);
      reset = 1'b0;
      first = 0;
      for (int j = 1; j <= 30; j++) begin
         rd(3'd4, v);
         if (v[2] && first == 0) first = j;
      end
      chk("btn2_after_reset", 64'(first - 1), 64'd18);
      rd(3'd0, v);
      chk("midrst_led", 64'(v), 64'h0);
      io_input_bus[12] = 1'b0;
      idle(25);

      foreach (hold[i]) hold[i] = int'($urandom_range(1, 40));
      for (int c = 0; c < 2000; c++) begin
         sel   = ($urandom_range(0, 3) != 0);
         we    = $urandom_range(0, 1) == 1;
         addr  = 3'($urandom_range(0, 7));
         wdata = $urandom;
         if ($urandom_range(0, 7) == 0) io_input_bus[9:0] = 10'($urandom);
         for (int i = 0; i < 4; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               io_input_bus[10+i] = ~io_input_bus[10+i];
               hold[i] = int'($urandom_range(1, 40));
            end
         end
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0;
      sel = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
